dircc_message_receiver: RTL and testbench
=========================================

DIRCC_MESSAGE_RECEIVER -- requirements
Module: dircc_message_receiver

Interface
REQ-001 Parameter HW_NODE_ID, default 1: hardware node address this receiver answers to.
REQ-002 Parameter DEVICE_COUNT, default 2: device instances hosted; legal sw_node is 0..DEVICE_COUNT-1.
REQ-003 Parameter IN_PORT_COUNT, default 1: input ports per device; legal port is 0..IN_PORT_COUNT-1.
REQ-004 Parameter PAYLOAD_WIDTH, default 32: message payload bits.
REQ-005 Parameter FIFO_DEPTH, default 4: ingress buffer entries; power of two, at least 2.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  ingress message valid.
REQ-009 in_ready  out  1  ingress can accept; deasserted when the FIFO is full.
REQ-010 in_hw_node  in  16  destination hardware node.
REQ-011 in_sw_node  in  16  destination device index.
REQ-012 in_port  in  8  destination input port index.
REQ-013 in_flag  in  8  address flags; bit0 BROADCAST, 0x00 NONE, other bits ignored.
REQ-014 in_payload  in  PAYLOAD_WIDTH  message body.
REQ-015 out_valid  out  1  delivery valid.
REQ-016 out_ready  in  1  device handler accepts delivery.
REQ-017 out_device  out  16  target device index.
REQ-018 out_port  out  8  target input port.
REQ-019 out_payload  out  PAYLOAD_WIDTH  message body.
REQ-020 drop_pulse  out  1  one-cycle pulse per discarded message.
REQ-021 rx_count  out  32  messages delivered (broadcast counts once per device); saturating.
REQ-022 drop_count  out  32  messages discarded; saturating.

Function
REQ-023 An ingress transfer occurs on a cycle with in_valid and in_ready both high; the full header and payload are written to the FIFO.
REQ-024 in_ready is high exactly when the FIFO is not full; with the FIFO full and the head popped in the same cycle, in_ready stays low (no combinational ready path).
REQ-025 The FSM has states IDLE, CHECK, DELIVER, BCAST.
REQ-026 IDLE: when the FIFO is non-empty, go to CHECK next cycle.
REQ-027 CHECK, one cycle, evaluates the FIFO head: if hw_node != HW_NODE_ID, or port >= IN_PORT_COUNT, or (BROADCAST clear and sw_node >= DEVICE_COUNT), pop the head, pulse drop_pulse, increment drop_count, return to IDLE.
REQ-028 CHECK, valid unicast: go to DELIVER with out_device = sw_node.
REQ-029 CHECK, valid broadcast: go to BCAST with out_device = 0; sw_node is ignored.
REQ-030 DELIVER: out_valid high and out_* held stable until out_ready; on the handshake cycle pop the head, increment rx_count, go to IDLE.
REQ-031 BCAST: out_valid high per device index; on each handshake increment rx_count and out_device; the handshake with out_device = DEVICE_COUNT-1 pops the head and goes to IDLE.
REQ-032 Minimum latency from ingress transfer into an empty FIFO to out_valid is 3 cycles (write, IDLE, CHECK); sustained unicast throughput is one message per 3 cycles with out_ready held high.
REQ-033 Ingress writes continue during CHECK/DELIVER/BCAST whenever the FIFO is not full; simultaneous push and pop keep occupancy unchanged.
REQ-034 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty come from the MSB comparison.
REQ-035 rx_count and drop_count hold at 0xFFFFFFFF instead of wrapping.
REQ-036 Messages leave in arrival order; a dropped message never blocks later ones.

Reset
REQ-037 Reset, at any point including mid-broadcast, empties the FIFO, sets state to IDLE, and clears out_valid, out_device, out_port, out_payload, drop_pulse, rx_count and drop_count to 0; in_ready is 1 on the first cycle after reset is released.
REQ-038 A message partly broadcast when reset asserts is discarded without further deliveries.

Verification
REQ-039 Unicast hw=1, sw=0, port=0, flag=0, payload 0xA5A5A5A5, out_ready high -> out_valid 3 cycles after ingress, device 0, port 0, payload 0xA5A5A5A5; rx_count=1.
REQ-040 hw=2 and, separately, sw=5 (flag 0) -> no out_valid, two drop_pulses, drop_count=2, rx_count=0.
REQ-041 Broadcast flag=0x01, sw=7, DEVICE_COUNT=2 -> deliveries to devices 0 then 1 with identical payload; rx_count=2.
REQ-042 out_ready low, 5 messages sent back-to-back -> in_ready low after 4 are accepted; out_* stable; releasing out_ready drains all 5 in order.
REQ-043 Reset asserted on the cycle after the first broadcast handshake -> all outputs 0, no delivery to device 1, in_ready=1 after release.
REQ-044 drop_count forced to 0xFFFFFFFE, three invalid messages sent -> drop_count stops at 0xFFFFFFFF.

Source files
------------

// File: rtl/dircc_message_receiver.sv
// Ingress FIFO plus address-check FSM that routes messages to local device
// handlers, fanning broadcasts out to every hosted device in index order.
module dircc_message_receiver #(
  parameter int HW_NODE_ID    = 1,
  parameter int DEVICE_COUNT  = 2,
  parameter int IN_PORT_COUNT = 1,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_hw_node,
  input  logic [15:0]              in_sw_node,
  input  logic [7:0]               in_port,
  input  logic [7:0]               in_flag,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_device,
  output logic [7:0]               out_port,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     drop_pulse,
  output logic [31:0]              rx_count,
  output logic [31:0]              drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, DELIVER, BCAST} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [15:0]              r_memHw      [FIFO_DEPTH];
  logic [15:0]              r_memSw      [FIFO_DEPTH];
  logic [7:0]               r_memPort    [FIFO_DEPTH];
  logic [7:0]               r_memFlag    [FIFO_DEPTH];
  logic [PAYLOAD_WIDTH-1:0] r_memPayload [FIFO_DEPTH];

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;

  logic [15:0]              r_outDevice;
  logic [7:0]               r_outPort;
  logic [PAYLOAD_WIDTH-1:0] r_outPayload;
  logic [31:0]              r_rxCount;
  logic [31:0]              r_dropCount;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;
  logic                     w_dropPulse;
  logic                     w_deliver;
  logic                     w_load;
  logic                     w_advance;
  logic                     w_lastDev;
  logic [15:0]              w_headHw;
  logic [15:0]              w_headSw;
  logic [7:0]               w_headPort;
  logic [7:0]               w_headFlag;
  logic [PAYLOAD_WIDTH-1:0] w_headPayload;
  logic                     w_headBcast;
  logic                     w_unusedFlagBits;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;

  assign w_headHw      = r_memHw[r_rdPtr[AW-1:0]];
  assign w_headSw      = r_memSw[r_rdPtr[AW-1:0]];
  assign w_headPort    = r_memPort[r_rdPtr[AW-1:0]];
  assign w_headFlag    = r_memFlag[r_rdPtr[AW-1:0]];
  assign w_headPayload = r_memPayload[r_rdPtr[AW-1:0]];
  assign w_headBcast   = w_headFlag[0];
  assign w_unusedFlagBits = ^w_headFlag[7:1];

  assign w_drop = (w_headHw != 16'(HW_NODE_ID)) ||
                  ({24'd0, w_headPort} >= 32'(IN_PORT_COUNT)) ||
                  (!w_headBcast && ({16'd0, w_headSw} >= 32'(DEVICE_COUNT)));

  assign w_lastDev = (r_outDevice == 16'(DEVICE_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_dropPulse = 1'b0;
    w_deliver   = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_nextState = CHECK;
      end
      CHECK: begin
        if (w_drop) begin
          w_pop       = 1'b1;
          w_dropPulse = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_load      = 1'b1;
          w_nextState = w_headBcast ? BCAST : DELIVER;
        end
      end
      DELIVER: begin
        if (out_ready) begin
          w_pop       = 1'b1;
          w_deliver   = 1'b1;
          w_nextState = IDLE;
        end
      end
      BCAST: begin
        if (out_ready) begin
          w_deliver = 1'b1;
          if (w_lastDev) begin
            w_pop       = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memHw[r_wrPtr[AW-1:0]]      <= in_hw_node;
      r_memSw[r_wrPtr[AW-1:0]]      <= in_sw_node;
      r_memPort[r_wrPtr[AW-1:0]]    <= in_port;
      r_memFlag[r_wrPtr[AW-1:0]]    <= in_flag;
      r_memPayload[r_wrPtr[AW-1:0]] <= in_payload;
    end
  end

  // Delivery fields are registered so reset leaves them at zero regardless of FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_outDevice  <= '0;
      r_outPort    <= '0;
      r_outPayload <= '0;
      r_rxCount    <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_load) begin
        r_outDevice  <= w_headBcast ? 16'd0 : w_headSw;
        r_outPort    <= w_headPort;
        r_outPayload <= w_headPayload;
      end else if (w_advance) begin
        r_outDevice <= r_outDevice + 16'd1;
      end
      if (w_deliver && (r_rxCount != 32'hFFFF_FFFF))     r_rxCount   <= r_rxCount + 32'd1;
      if (w_dropPulse && (r_dropCount != 32'hFFFF_FFFF)) r_dropCount <= r_dropCount + 32'd1;
    end
  end

  assign out_valid   = (r_state == DELIVER) || (r_state == BCAST);
  assign out_device  = r_outDevice;
  assign out_port    = r_outPort;
  assign out_payload = r_outPayload;
  assign drop_pulse  = w_dropPulse;
  assign rx_count    = r_rxCount;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_dircc_message_receiver.sv
// Scoreboard bench for dircc_message_receiver: expected deliveries are queued
// as messages are driven and matched in order as the receiver hands them out.
module tb_dircc_message_receiver;

  typedef struct packed {
    logic [15:0] dev;
    logic [7:0]  port;
    logic [31:0] payload;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_hw_node = '0;
  logic [15:0] in_sw_node = '0;
  logic [7:0]  in_port = '0;
  logic [7:0]  in_flag = '0;
  logic [31:0] in_payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_device;
  logic [7:0]  out_port;
  logic [31:0] out_payload;
  logic        drop_pulse;
  logic [31:0] rx_count;
  logic [31:0] drop_count;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   deliveries = 0;
  int   dropPulses = 0;
  int   validCycles = 0;

  dircc_message_receiver #(
    .HW_NODE_ID(1), .DEVICE_COUNT(2), .IN_PORT_COUNT(1),
    .PAYLOAD_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hw_node(in_hw_node), .in_sw_node(in_sw_node), .in_port(in_port),
    .in_flag(in_flag), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_device(out_device), .out_port(out_port), .out_payload(out_payload),
    .drop_pulse(drop_pulse), .rx_count(rx_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (drop_pulse) dropPulses++;
      if (out_valid) validCycles++;
      if (out_valid && out_ready) begin
        exp_t e;
        deliveries++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL delivery: unexpected dev=%0d port=%0d payload=%h, none required",
                   out_device, out_port, out_payload);
        end else begin
          e = expQ.pop_front();
          if ({out_device, out_port, out_payload} !== e) begin
            errors++;
            $display("[TB] FAIL delivery: got dev=%0d port=%0d payload=%h, required dev=%0d port=%0d payload=%h",
                     out_device, out_port, out_payload, e.dev, e.port, e.payload);
          end
        end
      end
    end
  end

  task automatic doReset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expQ.delete();
  endtask

  // Drives one message, queues what the receiver should deliver for it, and
  // returns just after the transfer edge with in_valid still asserted.
  task automatic sendMsg(input logic [15:0] hw, input logic [15:0] sw, input logic [7:0] port,
                         input logic [7:0] flag, input logic [31:0] payload);
    int n;
    exp_t e;
    in_valid = 1'b1; in_hw_node = hw; in_sw_node = sw;
    in_port = port; in_flag = flag; in_payload = payload;
    if (hw == 16'd1 && port < 8'd1) begin
      if (flag[0]) begin
        for (int d = 0; d < 2; d++) begin
          e.dev = 16'(d); e.port = port; e.payload = payload;
          expQ.push_back(e);
        end
      end else if (sw < 16'd2) begin
        e.dev = sw; e.port = port; e.payload = payload;
        expQ.push_back(e);
      end
    end
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || out_valid === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d deliveries outstanding, required 0", name, expQ.size());
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_hw_node = 16'd1; in_flag = 8'h01; in_payload = 32'hDEAD_BEEF;
    doReset();
    @(negedge clk);
    checks++;
    if ({out_valid, drop_pulse, in_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid/drop/ready=%b, required 001", {out_valid, drop_pulse, in_ready});
    end
    checks++;
    if ({out_device, out_port, out_payload, rx_count, drop_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: dev=%0d port=%0d payload=%h rx=%0d drop=%0d, required all 0",
               out_device, out_port, out_payload, rx_count, drop_count);
    end
  endtask

  task automatic test_unicast();
    int lat;
    doReset();
    out_ready = 1'b1;
    sendMsg(16'd1, 16'd0, 8'd0, 8'h00, 32'hA5A5_A5A5);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("[TB] FAIL unicast_latency: %0d cycles, required 3", lat);
    end
    waitDrain("unicast");
    checks++;
    if (rx_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL unicast_rx_count: %0d, required 1", rx_count);
    end
    sendMsg(16'd1, 16'd1, 8'd0, 8'hFE, 32'h1234_5678);
    in_valid = 1'b0;
    waitDrain("flag_ignored");
    checks++;
    if (rx_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL flag_ignored_rx_count: %0d, required 2", rx_count);
    end
  endtask

  task automatic test_throughput();
    int cyc = 0;
    int hs = 0;
    int firstHs = 0;
    int lastHs = 0;
    doReset();
    out_ready = 1'b1;
    sendMsg(16'd1, 16'd0, 8'd0, 8'h00, 32'h0000_0011);
    sendMsg(16'd1, 16'd1, 8'd0, 8'h00, 32'h0000_0022);
    sendMsg(16'd1, 16'd0, 8'd0, 8'h00, 32'h0000_0033);
    in_valid = 1'b0;
    while (hs < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        if (hs == 0) firstHs = cyc;
        lastHs = cyc;
        hs++;
      end
    end
    checks++;
    if (hs != 3 || (lastHs - firstHs) != 6) begin
      errors++;
      $display("[TB] FAIL throughput: %0d handshakes spanning %0d cycles, required 3 spanning 6",
               hs, lastHs - firstHs);
    end
    waitDrain("throughput");
  endtask

  task automatic test_drop();
    int d0, p0, v0;
    doReset();
    out_ready = 1'b1;
    d0 = deliveries; p0 = dropPulses; v0 = validCycles;
    sendMsg(16'd2, 16'd0, 8'd0, 8'h00, 32'h0BAD_0001);
    sendMsg(16'd1, 16'd5, 8'd0, 8'h00, 32'h0BAD_0002);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (dropPulses - p0 != 2) begin
      errors++;
      $display("[TB] FAIL drop_pulses: %0d, required 2", dropPulses - p0);
    end
    checks++;
    if (drop_count !== 32'd2 || rx_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL drop_counts: drop=%0d rx=%0d, required drop=2 rx=0", drop_count, rx_count);
    end
    checks++;
    if (validCycles != v0 || deliveries != d0) begin
      errors++;
      $display("[TB] FAIL drop_no_valid: %0d valid cycles, required 0", validCycles - v0);
    end
  endtask

  task automatic test_broadcast();
    int d0;
    doReset();
    out_ready = 1'b1;
    d0 = deliveries;
    sendMsg(16'd1, 16'd7, 8'd0, 8'h01, 32'hB0AD_CA57);
    in_valid = 1'b0;
    waitDrain("broadcast");
    checks++;
    if (rx_count !== 32'd2 || deliveries - d0 != 2) begin
      errors++;
      $display("[TB] FAIL broadcast_rx_count: rx=%0d deliveries=%0d, required 2 and 2",
               rx_count, deliveries - d0);
    end
  endtask

  task automatic test_back_to_back();
    bit stuck = 0;
    doReset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      sendMsg(16'd1, 16'(k % 2), 8'd0, 8'h00, 32'hC0DE_0000 + 32'(k));
    in_valid = 1'b1; in_hw_node = 16'd1; in_sw_node = 16'd1;
    in_port = 8'd0; in_flag = 8'h00; in_payload = 32'hC0DE_0004;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_device !== 16'd0 ||
          out_payload !== 32'hC0DE_0000) stuck = 1;
    end
    checks++;
    if (stuck) begin
      errors++;
      $display("[TB] FAIL full_hold: ready=%b valid=%b dev=%0d payload=%h, required ready=0 valid=1 dev=0 payload=c0de0000",
               in_ready, out_valid, out_device, out_payload);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    sendMsg(16'd1, 16'd1, 8'd0, 8'h00, 32'hC0DE_0004);
    in_valid = 1'b0;
    waitDrain("back_to_back");
    checks++;
    if (rx_count !== 32'd5) begin
      errors++;
      $display("[TB] FAIL back_to_back_rx_count: %0d, required 5", rx_count);
    end
  endtask

  task automatic test_reset_mid_bcast();
    int n = 0;
    int d0;
    doReset();
    out_ready = 1'b1;
    sendMsg(16'd1, 16'd3, 8'd0, 8'h01, 32'h5EED_5EED);
    in_valid = 1'b0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(out_valid && out_ready && out_device == 16'd0)) begin
      errors++;
      $display("[TB] FAIL mid_bcast_first: valid=%b dev=%0d, required valid=1 dev=0", out_valid, out_device);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    expQ.delete();
    d0 = deliveries;
    @(negedge clk);
    checks++;
    if ({out_valid, drop_pulse, out_device, out_port, out_payload, rx_count, drop_count} !== '0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_bcast_reset: valid=%b dev=%0d payload=%h rx=%0d ready=%b, required 0s and ready=1",
               out_valid, out_device, out_payload, rx_count, in_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (deliveries != d0 || rx_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_bcast_no_resume: deliveries=%0d rx=%0d, required 0 and 0",
               deliveries - d0, rx_count);
    end
  endtask

  task automatic test_saturation();
    int p0;
    doReset();
    out_ready = 1'b1;
    @(negedge clk);
    force dut.r_dropCount = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.r_dropCount;
    p0 = dropPulses;
    sendMsg(16'd3, 16'd0, 8'd0, 8'h00, 32'h0000_00A1);
    sendMsg(16'd1, 16'd0, 8'd1, 8'h01, 32'h0000_00A2);
    sendMsg(16'd1, 16'd2, 8'd0, 8'h00, 32'h0000_00A3);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (dropPulses - p0 != 3) begin
      errors++;
      $display("[TB] FAIL sat_pulses: %0d, required 3", dropPulses - p0);
    end
    checks++;
    if (drop_count !== 32'hFFFF_FFFF || rx_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL sat_drop_count: drop=%h rx=%0d, required drop=ffffffff rx=0", drop_count, rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_throughput();
    test_drop();
    test_broadcast();
    test_back_to_back();
    test_reset_mid_bcast();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
